mc_core: RTL
============

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 Parameter IMEM_AW, default 10: instruction-memory word-address width; pc is a word index of IMEM_AW bits.
REQ-002 Parameter NUM_REGS, default 32: architectural register count; the only legal values are 32 (RV32I) and 16 (RV32E).
REQ-003 Parameter SERIAL_SHIFT, default 1: 1 selects a serial shifter at 1 bit/cycle; 0 selects a single-cycle barrel shifter.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 imem_addr  output  IMEM_AW  instruction word address.
REQ-007 imem_rdata  input  32  instruction word; valid exactly one cycle after imem_addr is presented (synchronous read).
REQ-008 retire_valid  output  1  one-cycle pulse per completed instruction.
REQ-009 retire_pc  output  IMEM_AW  pc of the retiring instruction; valid while retire_valid=1.
REQ-010 halted  output  1  core stopped; held until rst.
REQ-011 illegal  output  1  halt caused by an illegal instruction; held until rst.
REQ-012 dbg_sel  input  5  register index for debug readback.
REQ-013 dbg_data  output  32  combinational value of register dbg_sel; 0 when dbg_sel=0 or dbg_sel>=NUM_REGS.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT; FETCH drives imem_addr=pc and then goes to DECODE.
REQ-015 DECODE SHALL latch imem_rdata, read rs1/rs2, classify the instruction, and go to EXEC if legal, to HALT with illegal=1 if illegal, or to HALT with illegal=0 on ECALL (0x00000073).
REQ-016 Legal R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND (funct7 0x00, or 0x20 only for SUB/SRA).
REQ-017 Legal I-type (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; imm = sign-extended instr[31:20].
REQ-018 Legal branches (opcode 1100011): BEQ and BNE; B-immediate sign-extended from 13 bits.
REQ-019 Any other encoding SHALL be illegal, including a branch with imm[1:0]!=0 and, when NUM_REGS=16, any rd/rs1/rs2 >= 16.
REQ-020 All arithmetic SHALL be 32-bit, modulo 2^32; SLT/SLTI compare signed; SLTU/SLTIU compare unsigned; the shift amount is operand_b[4:0].
REQ-021 With SERIAL_SHIFT=1, a shift SHALL stay in EXEC for max(shamt,1) cycles; all other instructions stay in EXEC for 1 cycle.
REQ-022 Each instruction SHALL take 4 cycles (FETCH, DECODE, EXEC, WB), plus shamt-1 extra cycles for a serial shift with shamt>1.
REQ-023 WB SHALL write the result to rd, pulse retire_valid with retire_pc, and return to FETCH.
REQ-024 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-025 Branches SHALL write no register; a taken branch sets pc = pc + (imm>>>2), otherwise pc = pc + 1.
REQ-026 All pc arithmetic SHALL wrap modulo 2^IMEM_AW.
REQ-027 HALT SHALL hold pc and all registers, drive no retire pulse, and exit only via rst.
REQ-028 ECALL and illegal instructions SHALL NOT retire; retire_pc is don't-care when retire_valid=0.
REQ-029 dbg_data SHALL reflect a WB write starting the cycle after that write's clock edge.

Reset
REQ-030 When rst=1 at a rising edge: pc=0, all registers=0, state=FETCH, retire_valid=0, halted=0, illegal=0, shift counter=0.
REQ-031 rst SHALL take priority in every state, including mid serial shift; a partially executed instruction is abandoned and does not retire.
REQ-032 imem_addr SHALL read 0 from the first cycle after reset.

Verification
REQ-033 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=0xFFFFFFF8, 4 retire pulses 4 cycles apart.
REQ-034 x1=0x80000000, SRAI x5,x1,31 with SERIAL_SHIFT=1 -> x5=0xFFFFFFFF, EXEC lasts 31 cycles, retire 34 cycles after FETCH; with SERIAL_SHIFT=0 -> same value, retire 4 cycles after FETCH.
REQ-035 BNE x0,x1 offset -4 at pc=0 with IMEM_AW=4 and x1!=0 -> next fetch pc=15 (wrap); BEQ not taken -> pc=1.
REQ-036 ADDI x0,x0,7 -> x0 remains 0 via dbg_sel=0, retire_valid still pulses.
REQ-037 Word 0xFFFFFFFF -> halted=1, illegal=1, no retire; ECALL -> halted=1, illegal=0; NUM_REGS=16 with ADD x17,.. -> illegal=1.
REQ-038 rst asserted 10 cycles into a 31-cycle serial shift -> no retire, the target register is unchanged (0), and fetch restarts at pc=0.

Source files
------------

// File: rtl/mc_core_if.sv
// Instruction fetch, retire, status and debug-readback signals of mc_core.
// master = core side, slave = instruction memory / observer side.
interface mc_core_if #(
   parameter int IMEM_AW = 10
);
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_rdata;
   logic               retire_valid;
   logic [IMEM_AW-1:0] retire_pc;
   logic               halted;
   logic               illegal;
   logic [4:0]         dbg_sel;
   logic [31:0]        dbg_data;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output retire_valid,
      output retire_pc,
      output halted,
      output illegal,
      input  dbg_sel,
      output dbg_data
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  retire_valid,
      input  retire_pc,
      input  halted,
      input  illegal,
      output dbg_sel,
      input  dbg_data
   );
endinterface

// File: rtl/mc_core.sv
// Multi-cycle RV32I/E integer subset core: FETCH, DECODE, EXEC, WB; 4 cycles per instruction,
// serial shifts add shamt-1 cycles. No backpressure: imem is a fixed 1-cycle synchronous read.
module mc_core #(
   parameter int IMEM_AW      = 10,
   parameter int NUM_REGS     = 32,
   parameter int SERIAL_SHIFT = 1
) (
   input  logic      clk,
   input  logic      rst,
   mc_core_if.master bus
);
   localparam int RW = $clog2(NUM_REGS);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

   state_t             state_q;
   logic [IMEM_AW-1:0] pc_q;
   logic [IMEM_AW-1:0] br_tgt_q;
   logic [IMEM_AW-1:0] retire_pc_q;
   logic [31:0]        regs_q [NUM_REGS];
   logic [31:0]        op_a_q;
   logic [31:0]        op_b_q;
   logic [31:0]        result_q;
   logic [4:0]         rd_q;
   logic [4:0]         shcnt_q;
   logic [2:0]         funct3_q;
   logic               alt_q;
   logic               is_branch_q;
   logic               is_shift_q;
   logic               retire_valid_q;
   logic               halted_q;
   logic               illegal_q;

   function automatic logic [31:0] rd_reg(input logic [4:0] idx);
      if (idx == 5'd0 || int'(idx) >= NUM_REGS) return 32'd0;
      return regs_q[idx[RW-1:0]];
   endfunction

   function automatic logic reg_ok(input logic [4:0] idx);
      return int'(idx) < NUM_REGS;
   endfunction

   logic [6:0]         dec_opc;
   logic [2:0]         dec_f3;
   logic [6:0]         dec_f7;
   logic [4:0]         dec_rd;
   logic [4:0]         dec_rs1;
   logic [4:0]         dec_rs2;
   logic               dec_r;
   logic               dec_i;
   logic               dec_b;
   logic               dec_legal;
   logic               dec_ecall;
   logic [31:0]        rs1_val_d;
   logic [31:0]        op_b_d;
   logic [IMEM_AW-1:0] br_off_d;

   always_comb begin
      dec_opc   = bus.imem_rdata[6:0];
      dec_f3    = bus.imem_rdata[14:12];
      dec_f7    = bus.imem_rdata[31:25];
      dec_rd    = bus.imem_rdata[11:7];
      dec_rs1   = bus.imem_rdata[19:15];
      dec_rs2   = bus.imem_rdata[24:20];
      dec_ecall = (bus.imem_rdata == 32'h0000_0073);
      dec_r     = (dec_opc == 7'b0110011) &&
                  ((dec_f7 == 7'h00) ||
                   (dec_f7 == 7'h20 && (dec_f3 == 3'b000 || dec_f3 == 3'b101)));
      dec_i     = 1'b0;
      if (dec_opc == 7'b0010011) begin
         if (dec_f3 == 3'b001)      dec_i = (dec_f7 == 7'h00);
         else if (dec_f3 == 3'b101) dec_i = (dec_f7 == 7'h00) || (dec_f7 == 7'h20);
         else                       dec_i = 1'b1;
      end
      // imm[1] of a B-immediate sits in instr[8]; a half-word offset is illegal
      dec_b     = (dec_opc == 7'b1100011) && (dec_f3[2:1] == 2'b00) && !bus.imem_rdata[8];
      dec_legal = (dec_r && reg_ok(dec_rd) && reg_ok(dec_rs1) && reg_ok(dec_rs2)) ||
                  (dec_i && reg_ok(dec_rd) && reg_ok(dec_rs1)) ||
                  (dec_b && reg_ok(dec_rs1) && reg_ok(dec_rs2));
      rs1_val_d = rd_reg(dec_rs1);
      op_b_d    = dec_i ? {{20{bus.imem_rdata[31]}}, bus.imem_rdata[31:20]} : rd_reg(dec_rs2);
      br_off_d  = IMEM_AW'($signed({bus.imem_rdata[31], bus.imem_rdata[7],
                                    bus.imem_rdata[30:25], bus.imem_rdata[11:9]}));
   end

   logic [4:0]  shamt_d;
   logic [31:0] result_d;
   logic [31:0] step_d;

   always_comb begin
      shamt_d  = op_b_q[4:0];
      result_d = 32'd0;
      case (funct3_q)
         3'b000: result_d = alt_q ? (op_a_q - op_b_q) : (op_a_q + op_b_q);
         3'b001: result_d = op_a_q << shamt_d;
         3'b010: result_d = {31'd0, $signed(op_a_q) < $signed(op_b_q)};
         3'b011: result_d = {31'd0, op_a_q < op_b_q};
         3'b100: result_d = op_a_q ^ op_b_q;
         3'b101: result_d = alt_q ? 32'($signed(op_a_q) >>> shamt_d) : (op_a_q >> shamt_d);
         3'b110: result_d = op_a_q | op_b_q;
         default: result_d = op_a_q & op_b_q;
      endcase
      step_d = (funct3_q == 3'b001) ? {result_q[30:0], 1'b0}
                                    : {alt_q & result_q[31], result_q[31:1]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= FETCH;
         pc_q           <= '0;
         br_tgt_q       <= '0;
         retire_pc_q    <= '0;
         op_a_q         <= '0;
         op_b_q         <= '0;
         result_q       <= '0;
         rd_q           <= '0;
         shcnt_q        <= '0;
         funct3_q       <= '0;
         alt_q          <= 1'b0;
         is_branch_q    <= 1'b0;
         is_shift_q     <= 1'b0;
         retire_valid_q <= 1'b0;
         halted_q       <= 1'b0;
         illegal_q      <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         retire_valid_q <= 1'b0;
         case (state_q)
            FETCH: state_q <= DECODE;
            DECODE: begin
               rd_q        <= dec_rd;
               funct3_q    <= dec_f3;
               alt_q       <= bus.imem_rdata[30] & (dec_r | (dec_f3 == 3'b101));
               is_branch_q <= dec_b;
               is_shift_q  <= !dec_b && (dec_f3 == 3'b001 || dec_f3 == 3'b101);
               op_a_q      <= rs1_val_d;
               op_b_q      <= op_b_d;
               result_q    <= rs1_val_d;
               shcnt_q     <= op_b_d[4:0];
               br_tgt_q    <= pc_q + br_off_d;
               if (dec_ecall) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else if (!dec_legal) begin
                  state_q   <= HALT;
                  halted_q  <= 1'b1;
                  illegal_q <= 1'b1;
               end else begin
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (is_shift_q && SERIAL_SHIFT != 0) begin
                  // one bit per cycle; a zero shift still spends one cycle here
                  if (shcnt_q > 5'd1) begin
                     result_q <= step_d;
                     shcnt_q  <= shcnt_q - 5'd1;
                  end else begin
                     if (shcnt_q == 5'd1) result_q <= step_d;
                     shcnt_q <= '0;
                     state_q <= WB;
                  end
               end else begin
                  result_q <= result_d;
                  state_q  <= WB;
               end
            end
            WB: begin
               if (!is_branch_q && rd_q != 5'd0) regs_q[rd_q[RW-1:0]] <= result_q;
               retire_valid_q <= 1'b1;
               retire_pc_q    <= pc_q;
               if (is_branch_q && ((op_a_q == op_b_q) ^ funct3_q[0])) pc_q <= br_tgt_q;
               else                                                  pc_q <= pc_q + IMEM_AW'(1);
               state_q <= FETCH;
            end
            HALT: state_q <= HALT;
            default: state_q <= FETCH;
         endcase
      end
   end

   assign bus.imem_addr    = pc_q;
   assign bus.retire_valid = retire_valid_q;
   assign bus.retire_pc    = retire_pc_q;
   assign bus.halted       = halted_q;
   assign bus.illegal      = illegal_q;
   assign bus.dbg_data     = rd_reg(bus.dbg_sel);
endmodule
